// File: rtl/ew_threat_core.sv
`default_nettype none
// ============================================================================
// Module      : ew_threat_core
// Description : Electronic-warfare threat FSM: classifies samples, hops the
//               comm channel, authenticates spoof events and logs threats.
// Revision    : 1.0 - initial release
// ============================================================================
module ew_threat_core #(
    parameter int DATA_W       = 8,
    parameter int NUM_CH       = 4,
    parameter int JAM_THRESH   = 200,
    parameter int SPOOF_CODE   = 123,
    parameter int PERSIST      = 2,
    parameter int RECOV_CYCLES = 4,
    parameter int AUTH_TIMEOUT = 8,
    parameter int MAX_FAULTS   = 3,
    localparam int CH_W = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic [DATA_W-1:0]        signal_in,
    input  logic [DATA_W-1:0]        command_in,
    input  logic [NUM_CH*DATA_W-1:0] ch_table,
    input  logic                     auth_ok,
    output logic [2:0]               fsm_state,
    output logic [CH_W-1:0]          comm_channel,
    output logic [DATA_W-1:0]        ch_freq,
    output logic                     system_fault,
    output logic [7:0]               threat_count,
    output logic [DATA_W-1:0]        last_cmd
);

    localparam int c_PERS_W = ($clog2(PERSIST + 1) < 1) ? 1 : $clog2(PERSIST + 1);
    localparam int c_TMR_W  = ($clog2(AUTH_TIMEOUT + 1) < 1) ? 1 : $clog2(AUTH_TIMEOUT + 1);
    localparam int c_REC_W  = ($clog2(RECOV_CYCLES + 1) < 1) ? 1 : $clog2(RECOV_CYCLES + 1);
    localparam int c_FLT_W  = ($clog2(MAX_FAULTS + 1) < 1) ? 1 : $clog2(MAX_FAULTS + 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_JAMMED       = 3'd1,
        S_SPOOF        = 3'd2,
        S_AUTH         = 3'd3,
        S_RECOVERY     = 3'd4,
        S_LOGGING      = 3'd5,
        S_THREAT_KNOWN = 3'd6
    } state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_ch;
    logic                r_fault;
    logic [7:0]          r_tc;
    logic [DATA_W-1:0]   r_last_cmd;
    logic                r_known;
    logic                r_ep_jam;
    logic [c_PERS_W-1:0] r_pers;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_REC_W-1:0]  r_recov;
    logic [c_FLT_W-1:0]  r_faults;

    logic                w_noise;
    logic                w_jam;
    logic                w_spoof;
    logic                w_qual;
    logic [c_PERS_W-1:0] w_pers_next;
    logic [c_FLT_W-1:0]  w_faults_inc;

    // Class priority: noise masks jam, jam masks spoof.
    assign w_noise      = sample_valid && (signal_in == {DATA_W{1'b1}});
    assign w_jam        = sample_valid && !w_noise && (int'(signal_in) >= JAM_THRESH);
    assign w_spoof      = sample_valid && !w_noise && !w_jam &&
                          (signal_in == DATA_W'(SPOOF_CODE));
    assign w_pers_next  = (r_pers == c_PERS_W'(PERSIST)) ? r_pers : r_pers + 1'b1;
    assign w_qual       = w_jam && (w_pers_next == c_PERS_W'(PERSIST));
    assign w_faults_inc = r_faults + 1'b1;

    function automatic logic [CH_W-1:0] hop(input logic [CH_W-1:0] ch, input int step);
        int s;
        s = (int'(ch) + step) % NUM_CH;
        return CH_W'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_fault    <= 1'b0;
            r_tc       <= '0;
            r_last_cmd <= '0;
            r_known    <= 1'b0;
            r_ep_jam   <= 1'b0;
            r_pers     <= '0;
            r_timer    <= '0;
            r_recov    <= '0;
            r_faults   <= '0;
        end else begin
            if (sample_valid) begin
                r_last_cmd <= command_in;
            end
            case (r_state)
                S_IDLE: begin
                    // A latched fault parks the core here until reset.
                    if (!r_fault) begin
                        if (sample_valid) begin
                            r_pers <= w_jam ? w_pers_next : '0;
                        end
                        if (w_noise) begin
                            r_state  <= S_LOGGING;
                            r_ep_jam <= 1'b0;
                            r_pers   <= '0;
                        end else if (w_qual) begin
                            r_state  <= r_known ? S_THREAT_KNOWN : S_JAMMED;
                            r_ep_jam <= 1'b1;
                            r_pers   <= '0;
                        end else if (w_spoof) begin
                            r_state  <= S_SPOOF;
                            r_ep_jam <= 1'b0;
                            r_pers   <= '0;
                        end
                    end
                end
                S_JAMMED: begin
                    r_ch    <= hop(r_ch, 1);
                    r_recov <= c_REC_W'(RECOV_CYCLES - 1);
                    r_state <= S_RECOVERY;
                end
                S_THREAT_KNOWN: begin
                    r_ch    <= hop(r_ch, 2);
                    r_recov <= c_REC_W'(RECOV_CYCLES - 1);
                    r_state <= S_RECOVERY;
                end
                S_SPOOF: begin
                    r_timer <= c_TMR_W'(AUTH_TIMEOUT);
                    r_state <= S_AUTH;
                end
                S_AUTH: begin
                    if (auth_ok) begin
                        r_recov <= c_REC_W'(RECOV_CYCLES - 1);
                        r_state <= S_RECOVERY;
                    end else if (r_timer <= c_TMR_W'(1)) begin
                        r_timer  <= '0;
                        r_faults <= w_faults_inc;
                        if (int'(w_faults_inc) >= MAX_FAULTS) begin
                            r_fault <= 1'b1;
                        end
                        r_state <= S_LOGGING;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_RECOVERY: begin
                    if (r_recov == '0) begin
                        r_state <= S_LOGGING;
                    end else begin
                        r_recov <= r_recov - 1'b1;
                    end
                end
                S_LOGGING: begin
                    if (r_tc != 8'hFF) begin
                        r_tc <= r_tc + 8'd1;
                    end
                    if (r_ep_jam) begin
                        r_known <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fsm_state    = r_state;
    assign comm_channel = r_ch;
    assign ch_freq      = ch_table[r_ch*DATA_W +: DATA_W];
    assign system_fault = r_fault;
    assign threat_count = r_tc;
    assign last_cmd     = r_last_cmd;

endmodule
`default_nettype wire

// File: tb/tb_ew_threat_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_ew_threat_core
// Description : Randomised episode-level bench for ew_threat_core with a
//               per-cycle expectation queue drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ew_threat_core;

    localparam int c_DW  = 8;
    localparam int c_NCH = 4;
    localparam int c_CHW = 2;
    localparam int c_IDLE = 0, c_JAM = 1, c_SPOOF = 2, c_AUTH = 3;
    localparam int c_RECOV = 4, c_LOG = 5, c_TK = 6;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   sample_valid = 1'b0;
    logic [c_DW-1:0]        signal_in = '0;
    logic [c_DW-1:0]        command_in = '0;
    logic [c_NCH*c_DW-1:0]  ch_table;
    logic                   auth_ok = 1'b0;
    logic [2:0]             fsm_state;
    logic [c_CHW-1:0]       comm_channel;
    logic [c_DW-1:0]        ch_freq;
    logic                   system_fault;
    logic [7:0]             threat_count;
    logic [c_DW-1:0]        last_cmd;

    ew_threat_core dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .signal_in    (signal_in),
        .command_in   (command_in),
        .ch_table     (ch_table),
        .auth_ok      (auth_ok),
        .fsm_state    (fsm_state),
        .comm_channel (comm_channel),
        .ch_freq      (ch_freq),
        .system_fault (system_fault),
        .threat_count (threat_count),
        .last_cmd     (last_cmd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic [c_CHW-1:0] ch;
        logic             flt;
        logic [7:0]       tc;
        logic [c_DW-1:0]  lc;
    } exp_t;

    exp_t            exp_q[$];
    logic [c_DW-1:0] ch_words[c_NCH];
    int              checks = 0;
    int              failures = 0;

    // Episode-level reference state.
    int              m_ch, m_tc, m_faults;
    bit              m_known, m_fault;
    logic [c_DW-1:0] m_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fsm_state",    int'(fsm_state),    int'(e.st));
            chk("comm_channel", int'(comm_channel), int'(e.ch));
            chk("ch_freq",      int'(ch_freq),      int'(ch_words[e.ch]));
            chk("system_fault", int'(system_fault), int'(e.flt));
            chk("threat_count", int'(threat_count), int'(e.tc));
            chk("last_cmd",     int'(last_cmd),     int'(e.lc));
        end
    end

    task automatic push_exp(input int est);
        exp_t e;
        e.st  = 3'(est);
        e.ch  = c_CHW'(m_ch);
        e.flt = m_fault;
        e.tc  = 8'(m_tc);
        e.lc  = m_last;
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs, take the edge, record what must follow it.
    task automatic cyc(input bit v, input logic [c_DW-1:0] s, input bit a, input int est);
        sample_valid = v;
        signal_in    = s;
        command_in   = c_DW'($urandom);
        auth_ok      = a;
        @(posedge clk);
        if (v) m_last = command_in;
        push_exp(est);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b1;
        signal_in    = 8'd220;
        command_in   = c_DW'($urandom);
        auth_ok      = 1'b1;
        @(posedge clk);
        m_ch = 0; m_tc = 0; m_faults = 0; m_known = 0; m_fault = 0; m_last = '0;
        push_exp(c_IDLE);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [c_DW-1:0] quiet_lvl();
        int s;
        do s = $urandom_range(0, 199); while (s == 123);
        return c_DW'(s);
    endfunction

    function automatic logic [c_DW-1:0] jam_lvl();
        return c_DW'($urandom_range(200, 254));
    endfunction

    function automatic void log_threat();
        m_tc = (m_tc < 255) ? m_tc + 1 : 255;
    endfunction

    // Cycles in a non-IDLE, non-AUTH state: every input is ignored but last_cmd.
    task automatic busy(input int n, input int est);
        repeat (n) cyc(1'($urandom_range(0, 1)), c_DW'($urandom), 1'($urandom_range(0, 1)), est);
    endtask

    task automatic quiet(input int n);
        repeat (n) cyc(1'($urandom_range(0, 1)), quiet_lvl(), 1'($urandom_range(0, 1)), c_IDLE);
    endtask

    task automatic locked(input int n);
        logic [c_DW-1:0] pick[4];
        pick[0] = 8'd220; pick[1] = 8'd123; pick[2] = 8'd255; pick[3] = c_DW'($urandom);
        repeat (n) cyc(1'($urandom_range(0, 1)), pick[$urandom_range(0, 3)],
                       1'($urandom_range(0, 1)), c_IDLE);
    endtask

    task automatic jam_start();
        bit kn;
        kn = m_known;
        cyc(1'b1, jam_lvl(), 1'($urandom_range(0, 1)), c_IDLE);
        repeat ($urandom_range(0, 3)) cyc(1'b0, c_DW'($urandom), 1'($urandom_range(0, 1)), c_IDLE);
        cyc(1'b1, jam_lvl(), 1'($urandom_range(0, 1)), kn ? c_TK : c_JAM);
        m_ch = (m_ch + (kn ? 2 : 1)) % c_NCH;
    endtask

    task automatic jam_episode();
        jam_start();
        busy(4, c_RECOV);
        busy(1, c_LOG);
        log_threat();
        m_known = 1'b1;
        busy(1, c_IDLE);
    endtask

    // auth_at = 1..8 raises auth_ok on that AUTHENTICATING cycle; 0 = timeout.
    task automatic spoof_episode(input int auth_at);
        bit done;
        done = 0;
        cyc(1'b1, 8'd123, 1'($urandom_range(0, 1)), c_SPOOF);
        busy(1, c_AUTH);
        for (int i = 1; i <= 8 && !done; i++) begin
            if (i == auth_at) begin
                cyc(1'($urandom_range(0, 1)), c_DW'($urandom), 1'b1, c_RECOV);
                busy(3, c_RECOV);
                busy(1, c_LOG);
                log_threat();
                busy(1, c_IDLE);
                done = 1;
            end else if (i < 8) begin
                cyc(1'($urandom_range(0, 1)), c_DW'($urandom), 1'b0, c_AUTH);
            end else begin
                m_faults++;
                if (m_faults >= 3) m_fault = 1'b1;
                cyc(1'($urandom_range(0, 1)), c_DW'($urandom), 1'b0, c_LOG);
                log_threat();
                busy(1, c_IDLE);
            end
        end
    endtask

    task automatic noise_episode();
        cyc(1'b1, 8'd255, 1'($urandom_range(0, 1)), c_LOG);
        log_threat();
        busy(1, c_IDLE);
    endtask

    task automatic single_jam();
        cyc(1'b1, jam_lvl(), 1'($urandom_range(0, 1)), c_IDLE);
        repeat ($urandom_range(0, 2)) cyc(1'b0, c_DW'($urandom), 1'($urandom_range(0, 1)), c_IDLE);
        cyc(1'b1, quiet_lvl(), 1'($urandom_range(0, 1)), c_IDLE);
    endtask

    initial begin
        int r;
        for (int k = 0; k < c_NCH; k++) begin
            ch_words[k] = c_DW'($urandom);
            ch_table[k*c_DW +: c_DW] = ch_words[k];
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        quiet(3);

        // Fresh jam, then two known-threat hops: 0->1, 1->3, 3->1.
        jam_episode();
        quiet(2);
        jam_episode();
        quiet(1);
        jam_episode();
        quiet(2);
        spoof_episode(3);
        spoof_episode(8);
        noise_episode();
        single_jam();
        quiet(2);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      jam_episode();
            else if (r < 70) spoof_episode($urandom_range(1, 8));
            else if (r < 85) noise_episode();
            else             single_jam();
            quiet($urandom_range(0, 3));
        end

        // Reset in the middle of RECOVERY clears everything incl. known flag.
        jam_start();
        busy(2, c_RECOV);
        do_reset();
        quiet(1);
        jam_episode();
        quiet(2);

        for (int n = 0; n < 3; n++) begin
            spoof_episode(0);
            quiet($urandom_range(0, 2));
        end
        locked(20);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
